// File: rtl/rv_iopmp_error_capture_fifo.sv
// rv_iopmp_error_capture_fifo
//   Queued IOPMP error recorder. Error reports from all instances are
//   arbitrated round-robin (one accepted per cycle) into a small FIFO. The
//   FIFO head is written into ERR_REQINFO/REQID/REQADDR/REQADDRH whenever the
//   ip bit reads clear. Errors that cannot be queued are counted and flagged.
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   reg2hw_err_*_i          current register contents (ip gates draining)
//   hw2reg_err_*_o          register update (.de=1 only in a drain cycle)
//   err_interface_i         per-instance error reports
//   ovf_clr_i               pulse: clear err_ovf_o / err_drop_cnt_o
//   err_queued_o            records held in the FIFO (0..FIFO_DEPTH)
//   err_ovf_o               sticky "an error was dropped"
//   err_drop_cnt_o          saturating dropped-error count

package iopmp_pkg;
    typedef struct packed {
        logic        error_detected;
        logic [1:0]  ttype;
        logic [3:0]  etype;
        logic [15:0] sid;
        logic [15:0] eid;
        logic [31:0] reqaddr;
        logic [31:0] reqaddrh;
    } error_capture_t;

    typedef struct packed { logic q; }        reg2hw_bit_t;
    typedef struct packed { logic [1:0] q; }  reg2hw_ttype_t;
    typedef struct packed { logic [3:0] q; }  reg2hw_etype_t;
    typedef struct packed { logic [15:0] q; } reg2hw_id_t;

    typedef struct packed {
        reg2hw_bit_t   ip;
        reg2hw_ttype_t ttype;
        reg2hw_etype_t etype;
    } iopmp_reg2hw_err_reqinfo_reg_t;
    typedef struct packed { reg2hw_id_t sid; reg2hw_id_t eid; } iopmp_reg2hw_err_reqid_reg_t;
    typedef struct packed { logic [31:0] q; } iopmp_reg2hw_err_reqaddr_reg_t;
    typedef struct packed { logic [31:0] q; } iopmp_reg2hw_err_reqaddrh_reg_t;

    typedef struct packed { logic d; logic de; }        hw2reg_bit_t;
    typedef struct packed { logic [1:0] d; logic de; }  hw2reg_ttype_t;
    typedef struct packed { logic [3:0] d; logic de; }  hw2reg_etype_t;
    typedef struct packed { logic [15:0] d; logic de; } hw2reg_id_t;

    typedef struct packed {
        hw2reg_bit_t   ip;
        hw2reg_ttype_t ttype;
        hw2reg_etype_t etype;
    } iopmp_hw2reg_err_reqinfo_reg_t;
    typedef struct packed { hw2reg_id_t sid; hw2reg_id_t eid; } iopmp_hw2reg_err_reqid_reg_t;
    typedef struct packed { logic [31:0] d; logic de; } iopmp_hw2reg_err_reqaddr_reg_t;
    typedef struct packed { logic [31:0] d; logic de; } iopmp_hw2reg_err_reqaddrh_reg_t;
endpackage

module rv_iopmp_error_capture_fifo
    import iopmp_pkg::*;
#(
    parameter int unsigned NUMBER_IOPMP_INSTANCES = 1,
    parameter int unsigned FIFO_DEPTH             = 4,
    parameter int unsigned DROP_CNT_WIDTH         = 8
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  iopmp_reg2hw_err_reqinfo_reg_t                  reg2hw_err_reqinfo_i,
    input  iopmp_reg2hw_err_reqid_reg_t                    reg2hw_err_reqid_i,
    input  iopmp_reg2hw_err_reqaddr_reg_t                  reg2hw_err_reqaddr_i,
    input  iopmp_reg2hw_err_reqaddrh_reg_t                 reg2hw_err_reqaddrh_i,
    output iopmp_hw2reg_err_reqinfo_reg_t                  hw2reg_err_reqinfo_o,
    output iopmp_hw2reg_err_reqid_reg_t                    hw2reg_err_reqid_o,
    output iopmp_hw2reg_err_reqaddr_reg_t                  hw2reg_err_reqaddr_o,
    output iopmp_hw2reg_err_reqaddrh_reg_t                 hw2reg_err_reqaddrh_o,
    input  error_capture_t [NUMBER_IOPMP_INSTANCES-1:0]    err_interface_i,
    input  logic                                           ovf_clr_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]                err_queued_o,
    output logic                                           err_ovf_o,
    output logic [DROP_CNT_WIDTH-1:0]                      err_drop_cnt_o
);
    localparam int unsigned N   = NUMBER_IOPMP_INSTANCES;
    localparam int unsigned RRW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned QW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW  = $clog2(N + 1);
    localparam int unsigned SW  = DROP_CNT_WIDTH + EW;

    typedef struct packed {
        logic [1:0]  ttype;
        logic [3:0]  etype;
        logic [15:0] sid;
        logic [15:0] eid;
        logic [31:0] addr;
        logic [31:0] addrh;
    } rec_t;

    rec_t                mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [QW-1:0]       count;
    logic [RRW-1:0]      rr_ptr;
    logic                lockout;

    logic                any_err, full, empty, drain, push;
    logic [RRW-1:0]      grant;
    logic [EW-1:0]       err_cnt, drops;
    int unsigned         idx;
    rec_t                sel;
    logic [SW-1:0]       cnt_sum;
    logic [DROP_CNT_WIDTH-1:0] cnt_next;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Round-robin search from rr_ptr; also counts every asserted error so the
    // losers can be charged to the drop counter.
    always_comb begin
        any_err = 1'b0;
        grant   = '0;
        sel     = '0;
        err_cnt = '0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(rr_ptr) + k) % N;
            if (!any_err && err_interface_i[idx].error_detected) begin
                any_err   = 1'b1;
                grant     = RRW'(idx);
                sel.ttype = err_interface_i[idx].ttype;
                sel.etype = err_interface_i[idx].etype;
                sel.sid   = err_interface_i[idx].sid;
                sel.eid   = err_interface_i[idx].eid;
                sel.addr  = err_interface_i[idx].reqaddr;
                sel.addrh = err_interface_i[idx].reqaddrh;
            end
            err_cnt = err_cnt + EW'(err_interface_i[k].error_detected);
        end
    end

    assign full  = (count == QW'(FIFO_DEPTH));
    assign empty = (count == '0);
    // lockout covers the cycle where our ip=1 write is not yet visible on ip.q
    assign drain = !empty && !reg2hw_err_reqinfo_i.ip.q && !lockout;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push  = any_err && (!full || drain);
    assign drops = err_cnt - EW'(push);

    // A clear discards the old count first; this cycle's drops still land.
    always_comb begin
        cnt_sum  = (ovf_clr_i ? '0 : SW'(err_drop_cnt_o)) + SW'(drops);
        cnt_next = (cnt_sum > SW'({DROP_CNT_WIDTH{1'b1}})) ? '1 : cnt_sum[DROP_CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            rr_ptr         <= '0;
            lockout        <= 1'b0;
            err_ovf_o      <= 1'b0;
            err_drop_cnt_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
                rr_ptr <= (grant == RRW'(N - 1)) ? '0 : grant + RRW'(1);
            end
            if (drain) rd_ptr <= ptr_inc(rd_ptr);
            count          <= count + QW'(push) - QW'(drain);
            lockout        <= drain;
            err_ovf_o      <= (err_ovf_o && !ovf_clr_i) || (drops != '0);
            err_drop_cnt_o <= cnt_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= sel;
    end

    assign err_queued_o = count;

    always_comb begin
        hw2reg_err_reqinfo_o.ip.d     = reg2hw_err_reqinfo_i.ip.q;
        hw2reg_err_reqinfo_o.ttype.d  = reg2hw_err_reqinfo_i.ttype.q;
        hw2reg_err_reqinfo_o.etype.d  = reg2hw_err_reqinfo_i.etype.q;
        hw2reg_err_reqid_o.sid.d      = reg2hw_err_reqid_i.sid.q;
        hw2reg_err_reqid_o.eid.d      = reg2hw_err_reqid_i.eid.q;
        hw2reg_err_reqaddr_o.d        = reg2hw_err_reqaddr_i.q;
        hw2reg_err_reqaddrh_o.d       = reg2hw_err_reqaddrh_i.q;
        hw2reg_err_reqinfo_o.ip.de    = drain;
        hw2reg_err_reqinfo_o.ttype.de = drain;
        hw2reg_err_reqinfo_o.etype.de = drain;
        hw2reg_err_reqid_o.sid.de     = drain;
        hw2reg_err_reqid_o.eid.de     = drain;
        hw2reg_err_reqaddr_o.de       = drain;
        hw2reg_err_reqaddrh_o.de      = drain;
        if (drain) begin
            hw2reg_err_reqinfo_o.ip.d    = 1'b1;
            hw2reg_err_reqinfo_o.ttype.d = mem[rd_ptr].ttype;
            hw2reg_err_reqinfo_o.etype.d = mem[rd_ptr].etype;
            hw2reg_err_reqid_o.sid.d     = mem[rd_ptr].sid;
            hw2reg_err_reqid_o.eid.d     = mem[rd_ptr].eid;
            hw2reg_err_reqaddr_o.d       = mem[rd_ptr].addr;
            hw2reg_err_reqaddrh_o.d      = mem[rd_ptr].addrh;
        end
    end

endmodule

// File: tb/tb_rv_iopmp_error_capture_fifo.sv
// Bench for rv_iopmp_error_capture_fifo (4 instances, depth 4, 4-bit drop
// counter). The bench owns the ERR_* registers, a queue-based reference model,
// a hand-computed vector table, and random traffic.
module tb_rv_iopmp_error_capture_fifo;
    import iopmp_pkg::*;

    localparam int N = 4, DEPTH = 4, DW = 4, CNT_MAX = 15;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    iopmp_reg2hw_err_reqinfo_reg_t  r_info;
    iopmp_reg2hw_err_reqid_reg_t    r_id;
    iopmp_reg2hw_err_reqaddr_reg_t  r_addr;
    iopmp_reg2hw_err_reqaddrh_reg_t r_addrh;
    iopmp_hw2reg_err_reqinfo_reg_t  h_info;
    iopmp_hw2reg_err_reqid_reg_t    h_id;
    iopmp_hw2reg_err_reqaddr_reg_t  h_addr;
    iopmp_hw2reg_err_reqaddrh_reg_t h_addrh;
    error_capture_t [N-1:0]         errs;
    logic                           ovf_clr, sw_clr;
    logic [2:0]                     queued;
    logic                           ovf;
    logic [DW-1:0]                  dcnt;

    rv_iopmp_error_capture_fifo #(
        .NUMBER_IOPMP_INSTANCES(N), .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(DW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .reg2hw_err_reqinfo_i(r_info), .reg2hw_err_reqid_i(r_id),
        .reg2hw_err_reqaddr_i(r_addr), .reg2hw_err_reqaddrh_i(r_addrh),
        .hw2reg_err_reqinfo_o(h_info), .hw2reg_err_reqid_o(h_id),
        .hw2reg_err_reqaddr_o(h_addr), .hw2reg_err_reqaddrh_o(h_addrh),
        .err_interface_i(errs), .ovf_clr_i(ovf_clr),
        .err_queued_o(queued), .err_ovf_o(ovf), .err_drop_cnt_o(dcnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]  ttype;
        logic [3:0]  etype;
        logic [15:0] sid, eid;
        logic [31:0] lo, hi;
    } rec_t;
    rec_t mq[$];
    int   m_rr, m_cnt;
    bit   m_ovf, m_last_drain;

    int vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rr = 0; m_cnt = 0; m_ovf = 0; m_last_drain = 0;
    endtask

    task automatic set_errs(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            errs[i].error_detected = mask[i];
            errs[i].ttype    = 2'($urandom);
            errs[i].etype    = 4'($urandom);
            errs[i].sid      = 16'($urandom);
            errs[i].eid      = 16'($urandom);
            errs[i].reqaddr  = $urandom;
            errs[i].reqaddrh = $urandom;
        end
    endtask

    // Called just after a negedge with inputs applied. Checks outputs against
    // the model, then advances model and register file across one posedge.
    task automatic step();
        bit drain, pushed;
        rec_t head, r;
        int nerr, g, drops;
        iopmp_hw2reg_err_reqinfo_reg_t  e_info;
        iopmp_hw2reg_err_reqid_reg_t    e_id;
        iopmp_hw2reg_err_reqaddr_reg_t  e_addr;
        iopmp_hw2reg_err_reqaddrh_reg_t e_addrh;
        #1;
        drain = (mq.size() > 0) && !r_info.ip.q && !m_last_drain;
        if (drain) head = mq[0];
        e_info.ip.d     = drain ? 1'b1 : r_info.ip.q;
        e_info.ttype.d  = drain ? head.ttype : r_info.ttype.q;
        e_info.etype.d  = drain ? head.etype : r_info.etype.q;
        e_id.sid.d      = drain ? head.sid : r_id.sid.q;
        e_id.eid.d      = drain ? head.eid : r_id.eid.q;
        e_addr.d        = drain ? head.lo : r_addr.q;
        e_addrh.d       = drain ? head.hi : r_addrh.q;
        e_info.ip.de = drain; e_info.ttype.de = drain; e_info.etype.de = drain;
        e_id.sid.de = drain; e_id.eid.de = drain; e_addr.de = drain; e_addrh.de = drain;
        chk("reqinfo", 64'(h_info), 64'(e_info));
        chk("reqid", 64'(h_id), 64'(e_id));
        chk("reqaddr", 64'(h_addr), 64'(e_addr));
        chk("reqaddrh", 64'(h_addrh), 64'(e_addrh));
        chk("queued", 64'(queued), 64'(mq.size()));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("drop_cnt", 64'(dcnt), 64'(m_cnt));

        if (drain) void'(mq.pop_front());
        nerr = 0; g = -1;
        for (int k = 0; k < N; k++) begin
            if (errs[k].error_detected) nerr++;
            if (g < 0 && errs[(m_rr + k) % N].error_detected) g = (m_rr + k) % N;
        end
        pushed = (nerr > 0) && (mq.size() < DEPTH);
        if (pushed) begin
            r.ttype = errs[g].ttype; r.etype = errs[g].etype;
            r.sid = errs[g].sid; r.eid = errs[g].eid;
            r.lo = errs[g].reqaddr; r.hi = errs[g].reqaddrh;
            mq.push_back(r);
            m_rr = (g + 1) % N;
        end
        drops = nerr - (pushed ? 1 : 0);
        m_cnt = (ovf_clr ? 0 : m_cnt) + drops;
        if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
        m_ovf = (ovf_clr ? 1'b0 : m_ovf) | (drops > 0);
        m_last_drain = drain;

        @(posedge clk); #1;
        if (drain) begin
            r_info.ip.q = 1'b1; r_info.ttype.q = head.ttype; r_info.etype.q = head.etype;
            r_id.sid.q = head.sid; r_id.eid.q = head.eid;
            r_addr.q = head.lo; r_addrh.q = head.hi;
        end else if (sw_clr) begin
            r_info.ip.q = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    // Expected values are the outputs seen before the edge of each row.
    typedef struct {
        logic [N-1:0] mask;
        logic sw, oc;
        int q;
        logic de, ov;
        int cnt;
    } vec_t;
    vec_t tbl[26];

    initial begin
        // ordered drain: three records while ip=1, then one per ip clear
        tbl[0]  = '{4'b0001, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{4'b0001, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{4'b0001, 0, 0, 2, 0, 0, 0};
        tbl[3]  = '{4'b0000, 1, 0, 3, 0, 0, 0};
        tbl[4]  = '{4'b0000, 0, 0, 3, 1, 0, 0};
        tbl[5]  = '{4'b0000, 0, 0, 2, 0, 0, 0};
        tbl[6]  = '{4'b0000, 1, 0, 2, 0, 0, 0};
        tbl[7]  = '{4'b0000, 0, 0, 2, 1, 0, 0};
        tbl[8]  = '{4'b0000, 0, 0, 1, 0, 0, 0};
        tbl[9]  = '{4'b0000, 1, 0, 1, 0, 0, 0};
        tbl[10] = '{4'b0000, 0, 0, 1, 1, 0, 0};
        tbl[11] = '{4'b0000, 0, 0, 0, 0, 0, 0};
        // instances 0 and 2 colliding for four cycles: one loser per cycle
        tbl[12] = '{4'b0101, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{4'b0101, 0, 0, 1, 0, 1, 1};
        tbl[14] = '{4'b0101, 0, 0, 2, 0, 1, 2};
        tbl[15] = '{4'b0101, 0, 0, 3, 0, 1, 3};
        // full FIFO: clear, drop while full, then pop+push in the drain cycle
        tbl[16] = '{4'b0000, 0, 1, 4, 0, 1, 4};
        tbl[17] = '{4'b0001, 1, 0, 4, 0, 0, 0};
        tbl[18] = '{4'b0010, 0, 0, 4, 1, 1, 1};
        // clear and a drop in the same cycle
        tbl[19] = '{4'b0001, 0, 1, 4, 0, 1, 1};
        tbl[20] = '{4'b0000, 0, 0, 4, 0, 1, 1};
        // saturation of the 4-bit counter
        tbl[21] = '{4'b1111, 0, 0, 4, 0, 1, 1};
        tbl[22] = '{4'b1111, 0, 0, 4, 0, 1, 5};
        tbl[23] = '{4'b1111, 0, 0, 4, 0, 1, 9};
        tbl[24] = '{4'b1111, 0, 0, 4, 0, 1, 13};
        tbl[25] = '{4'b0000, 0, 0, 4, 0, 1, 15};
    end

    initial begin
        r_info = '0; r_id = '0; r_addr = '0; r_addrh = '0;
        errs = '0; ovf_clr = 1'b0; sw_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_queued", 64'(queued), 64'd0);
        chk("rst_de", 64'(h_info.ip.de | h_addr.de | h_id.sid.de), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_cnt", 64'(dcnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single error, ip=0: registers written one cycle later
        set_errs(4'b0001);
        errs[0].sid = 16'd3; errs[0].reqaddr = 32'h40; errs[0].reqaddrh = 32'h1;
        errs[0].ttype = 2'd1; errs[0].etype = 4'd2;
        step();
        set_errs(4'b0000);
        #1;
        chk("t1_de", 64'({h_info.ip.de, h_info.ttype.de, h_info.etype.de, h_id.sid.de,
                          h_id.eid.de, h_addr.de, h_addrh.de}), 64'h7f);
        chk("t1_addr", 64'(h_addr.d), 64'h40);
        chk("t1_addrh", 64'(h_addrh.d), 64'h1);
        chk("t1_ip", 64'(h_info.ip.d), 64'd1);
        chk("t1_sid_type", 64'({h_id.sid.d, h_info.ttype.d, h_info.etype.d}), {42'd0, 16'd3, 2'd1, 4'd2});
        step();
        step();

        // table sequence from a clean state with ip=1
        do_reset();
        r_info.ip.q = 1'b1;
        foreach (tbl[i]) begin
            set_errs(tbl[i].mask);
            sw_clr = tbl[i].sw; ovf_clr = tbl[i].oc;
            #1;
            chk($sformatf("tbl%0d_queued", i), 64'(queued), 64'(tbl[i].q));
            chk($sformatf("tbl%0d_de", i), 64'(h_info.ip.de), 64'(tbl[i].de));
            chk($sformatf("tbl%0d_ovf", i), 64'(ovf), 64'(tbl[i].ov));
            chk($sformatf("tbl%0d_cnt", i), 64'(dcnt), 64'(tbl[i].cnt));
            step();
        end
        sw_clr = 1'b0; ovf_clr = 1'b0;

        // random traffic
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] m;
            for (int i = 0; i < N; i++) m[i] = ($urandom_range(0, 3) == 0);
            set_errs(m);
            sw_clr  = r_info.ip.q && ($urandom_range(0, 2) == 0);
            ovf_clr = ($urandom_range(0, 19) == 0);
            step();
        end
        sw_clr = 1'b0; ovf_clr = 1'b0;

        // asynchronous reset with records queued and a drain pending
        do_reset();
        r_info.ip.q = 1'b1;
        set_errs(4'b0001); step();
        set_errs(4'b0010); step();
        set_errs(4'b0000); sw_clr = 1'b1; step();
        sw_clr = 1'b0;
        #2;
        chk("pre_rst_de", 64'(h_info.ip.de), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_queued", 64'(queued), 64'd0);
        chk("async_rst_de", 64'({h_info.ip.de, h_addr.de, h_addrh.de, h_id.sid.de}), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
